// File: rtl/gba_vga_scaler.sv
// Double-buffered 240x160 -> 480x320 (2x2) scaler between a GBA pixel stream and a 640x480 VGA scan.
// Define GBA_SCALER_UNDERRUN_MARK_EN to paint window pixels of invalid lines magenta.
module gba_vga_scaler #(
    parameter int          H_OFS        = 80,
    parameter int          V_OFS        = 80,
    parameter logic [14:0] BORDER_COLOR = 15'h0000
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [14:0] pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [14:0] d_out,
    output logic        underrun
);

`ifdef GBA_SCALER_UNDERRUN_MARK_EN
    localparam logic [14:0] INVALID_COLOR = 15'h7C1F;
`else
    localparam logic [14:0] INVALID_COLOR = BORDER_COLOR;
`endif

    localparam logic [9:0] COL_LO = 10'(H_OFS);
    localparam logic [8:0] ROW_LO = 9'(V_OFS);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t      r_state, w_state_n;
    logic [1:0]  r_full, w_full_n;
    logic        r_wsel, w_wsel_n;
    logic [7:0]  r_wcol, w_wcol_n;
    logic [7:0]  r_wline, w_wline_n;
    logic        r_underrun, w_underrun_n;
    logic        r_ready, w_ready_n;
    logic        r_lv, w_lv_n;

    logic [14:0] r_buf0 [0:239];
    logic [14:0] r_buf1 [0:239];

    logic        w_wr_en, w_wr_sel, w_accept;
    logic [7:0]  w_wr_col;
    logic [9:0]  w_dx;
    logic [8:0]  w_dy;
    logic [7:0]  w_gx;
    logic        w_gy0, w_odd, w_in_win, w_sample, w_release, w_line_ok;
    logic [14:0] w_rd_pix;

    // Reader: window decode and 2x2 address mapping
    assign w_dx      = col_addr - COL_LO;
    assign w_dy      = row_addr - ROW_LO;
    assign w_gx      = w_dx[8:1];
    assign w_gy0     = w_dy[1];
    assign w_odd     = w_dy[0];
    assign w_in_win  = !rdn && (col_addr >= COL_LO) && (w_dx < 10'd480)
                            && (row_addr >= ROW_LO) && (w_dy < 9'd320);
    assign w_sample  = w_in_win && !w_odd && (w_dx == 10'd0);
    assign w_release = w_in_win && w_odd && (w_dx == 10'd479) && r_lv;
    // Validity is decided on the sampling pixel itself, so that pixel needs the live flag.
    assign w_line_ok = w_sample ? r_full[w_gy0] : r_lv;
    assign w_rd_pix  = w_gy0 ? r_buf1[w_gx] : r_buf0[w_gx];

    always_comb begin
        d_out = BORDER_COLOR;
        if (clrn && w_in_win) begin
            d_out = w_line_ok ? w_rd_pix : INVALID_COLOR;
        end
    end

    // Writer next-state, flag bookkeeping and underrun detection
    always_comb begin
        w_state_n    = r_state;
        w_full_n     = r_full;
        w_wsel_n     = r_wsel;
        w_wcol_n     = r_wcol;
        w_wline_n    = r_wline;
        w_wr_en      = 1'b0;
        w_wr_sel     = r_wsel;
        w_wr_col     = r_wcol;
        w_accept     = pix_valid && r_ready;
        w_lv_n       = w_sample ? r_full[w_gy0] : r_lv;
        w_underrun_n = r_underrun | (w_sample && !r_full[w_gy0]);

        if (w_release) begin
            w_full_n[w_gy0] = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept && pix_sof) begin
                    w_wr_en   = 1'b1;
                    w_wr_sel  = 1'b0;
                    w_wr_col  = 8'd0;
                    w_state_n = S_FILL;
                    w_wcol_n  = 8'd1;
                    w_wline_n = 8'd0;
                    w_wsel_n  = 1'b0;
                end
            end
            S_FILL: begin
                if (w_accept && pix_sof) begin
                    w_full_n     = 2'b00;
                    w_wr_en      = 1'b1;
                    w_wr_sel     = 1'b0;
                    w_wr_col     = 8'd0;
                    w_wcol_n     = 8'd1;
                    w_wline_n    = 8'd0;
                    w_wsel_n     = 1'b0;
                    w_underrun_n = 1'b1;
                end else if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (r_wcol == 8'd239) begin
                        w_full_n[r_wsel] = 1'b1;
                        w_wsel_n         = ~r_wsel;
                        w_wcol_n         = 8'd0;
                        if (r_wline == 8'd159) begin
                            w_state_n = S_IDLE;
                            w_wline_n = 8'd0;
                        end else begin
                            w_wline_n = r_wline + 8'd1;
                        end
                    end else begin
                        w_wcol_n = r_wcol + 8'd1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        w_ready_n = (w_state_n == S_IDLE) ? 1'b1 : ~w_full_n[w_wsel_n];
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_full     <= 2'b00;
            r_wsel     <= 1'b0;
            r_wcol     <= 8'd0;
            r_wline    <= 8'd0;
            r_underrun <= 1'b0;
            r_ready    <= 1'b0;
            r_lv       <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_full     <= w_full_n;
            r_wsel     <= w_wsel_n;
            r_wcol     <= w_wcol_n;
            r_wline    <= w_wline_n;
            r_underrun <= w_underrun_n;
            r_ready    <= w_ready_n;
            r_lv       <= w_lv_n;
        end
    end

    // Line storage is deliberately left out of reset.
    always_ff @(posedge vga_clk) begin
        if (w_wr_en) begin
            if (w_wr_sel) begin
                r_buf1[w_wr_col] <= pix_in;
            end else begin
                r_buf0[w_wr_col] <= pix_in;
            end
        end
    end

    assign pix_ready = r_ready;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_gba_vga_scaler.sv
// Directed bench for gba_vga_scaler: fill, 2x2 display, flow control, resync, reset and border cases.
module tb_gba_vga_scaler;

    localparam logic [14:0] BC = 15'h1234;
`ifdef GBA_SCALER_UNDERRUN_MARK_EN
    localparam logic [14:0] INV = 15'h7C1F;
`else
    localparam logic [14:0] INV = BC;
`endif

    logic        clk;
    logic        clrn;
    logic [14:0] pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [14:0] d_out;
    logic        underrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    gba_vga_scaler #(
        .H_OFS        (80),
        .V_OFS        (80),
        .BORDER_COLOR (BC)
    ) dut (
        .vga_clk   (clk),
        .clrn      (clrn),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .rdn       (rdn),
        .d_out     (d_out),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1000000");
        $fatal(1);
    end

    // kind 0: {line[4:0], col[7:3], 5'h0}; kind 1: 15'h4000|col; kind 2: 15'h2000|col
    function automatic logic [14:0] pat(input int kind, input int line, input int col);
        logic [7:0] c8;
        logic [7:0] l8;
        c8 = 8'(col);
        l8 = 8'(line);
        case (kind)
            0:       return {l8[4:0], c8[7:3], 5'b0};
            1:       return {7'h40, c8};
            default: return {7'h20, c8};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, input int c, input logic n);
        row_addr = 9'(r);
        col_addr = 10'(c);
        rdn      = n;
        #1;
    endtask

    task automatic push(input int kind, input int line, input int col, input int n,
                        input bit sof_first, output int cycles);
        int   acc_n;
        int   cy;
        int   l;
        int   c;
        logic acc;
        acc_n = 0;
        cy    = 0;
        l     = line;
        c     = col;
        while (acc_n < n && cy < 4 * n + 20) begin
            pix_valid = 1'b1;
            pix_sof   = sof_first && (acc_n == 0);
            pix_in    = pat(kind, l, c);
            acc       = pix_ready;
            tick();
            cy++;
            if (acc) begin
                acc_n++;
                c++;
                if (c == 240) begin
                    c = 0;
                    l++;
                end
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check("push_count", acc_n, n);
        cycles = cy;
    endtask

    task automatic show(input int gy);
        rd(80 + 2 * gy, 80, 1'b0);
        check($sformatf("line%0d_c0", gy), d_out, pat(0, gy, 0));
        tick();
        rd(81 + 2 * gy, 559, 1'b0);
        check($sformatf("line%0d_c239", gy), d_out, pat(0, gy, 239));
        tick();
        rdn = 1'b1;
    endtask

    initial begin
        clrn      = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = 15'h0;
        row_addr  = 9'd0;
        col_addr  = 10'd0;
        rdn       = 1'b1;
        repeat (3) tick();

        // Reset state
        rd(100, 100, 1'b0);
        check("rst_dout", d_out, BC);
        check("rst_ready", pix_ready, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        rdn  = 1'b1;
        clrn = 1'b1;
        tick();
        check("ready_after_rst", pix_ready, 1'b1);

        // Two lines with continuous valid: both buffers fill, then backpressure
        push(0, 0, 0, 480, 1'b1, cyc);
        check("fill480_cycles", cyc, 480);
        check("ready_full", pix_ready, 1'b0);

        // Pair 0 in detail, ending in the release of B0
        rd(80, 80, 1'b0);
        check("r80c80", d_out, 15'h0000);
        tick();
        rd(80, 81, 1'b0);
        check("r80c81", d_out, 15'h0000);
        rd(80, 559, 1'b0);
        check("r80c559", d_out, 15'h03A0);
        rd(81, 80, 1'b0);
        check("r81c80", d_out, 15'h0000);
        rd(81, 300, 1'b0);
        check("r81c300", d_out, 15'h01A0);
        rd(81, 559, 1'b0);
        check("r81c559", d_out, 15'h03A0);
        check("ready_before_rel", pix_ready, 1'b0);
        tick();
        check("ready_after_rel", pix_ready, 1'b1);

        // Outside-window border
        rd(79, 100, 1'b0);
        check("row79", d_out, BC);
        rd(400, 100, 1'b0);
        check("row400", d_out, BC);
        rd(100, 79, 1'b0);
        check("col79", d_out, BC);
        rd(100, 560, 1'b0);
        check("col560", d_out, BC);
        rd(100, 100, 1'b1);
        check("rdn_high", d_out, BC);
        check("underrun_clean", underrun, 1'b0);

        // Stream lines 2..36, displaying and releasing lines 1..35 in between
        for (int l = 2; l <= 36; l++) begin
            push(0, l, 0, 240, 1'b0, cyc);
            show(l - 1);
        end
        push(0, 37, 0, 100, 1'b0, cyc);
        check("pre_resync_underrun", underrun, 1'b0);

        // Mid-frame resync at line 37 col 100
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_in    = pat(1, 0, 0);
        check("resync_ready", pix_ready, 1'b1);
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check("resync_underrun", underrun, 1'b1);
        check("resync_f0_clear", pix_ready, 1'b1);
        push(1, 0, 1, 239, 1'b0, cyc);
        check("resync_f1_clear", pix_ready, 1'b1);
        rd(80, 80, 1'b0);
        check("resync_b0_0", d_out, 15'h4000);
        tick();
        rd(80, 280, 1'b0);
        check("resync_b0_100", d_out, 15'h4064);
        rd(81, 559, 1'b0);
        check("resync_b0_239", d_out, 15'h40EF);
        rdn = 1'b1;

        // Reset during FILL with B0 still full
        push(1, 1, 0, 50, 1'b0, cyc);
        pix_valid = 1'b1;
        pix_in    = 15'h0055;
        clrn      = 1'b0;
        rd(80, 100, 1'b0);
        check("mid_rst_dout", d_out, BC);
        check("mid_rst_ready0", pix_ready, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("mid_rst_ready%0d", i), pix_ready, 1'b0);
        end
        rdn       = 1'b1;
        pix_valid = 1'b0;
        clrn      = 1'b1;
        tick();
        check("post_rst_ready", pix_ready, 1'b1);
        check("post_rst_underrun", underrun, 1'b0);

        // Pixels without sof after reset are discarded
        push(2, 0, 0, 240, 1'b0, cyc);
        rd(80, 80, 1'b0);
        check("no_sof_inv_r80", d_out, INV);
        tick();
        check("no_sof_underrun", underrun, 1'b1);
        rd(81, 100, 1'b0);
        check("no_sof_inv_r81", d_out, INV);
        rdn = 1'b1;

        // Next sof starts a fresh frame
        push(2, 0, 0, 240, 1'b1, cyc);
        rd(80, 80, 1'b0);
        check("new_frame_c0", d_out, 15'h2000);
        tick();
        rd(81, 559, 1'b0);
        check("new_frame_c239", d_out, 15'h20EF);
        check("underrun_sticky", underrun, 1'b1);
        rdn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
